// File: rtl/ch_param_pkg.sv
// ch_param_pkg: shared types and helpers for the double-buffered channel
// parameter store (ch_param_ram and its per-table ch_param_bank).
//   state_e  - top-level controller states
//   mem_op_e - per-cycle operation applied to a table memory
//   TAB_*    - table indices within the host address map / lk_data bus
//   tab_base - host word address of entry 0 of a table
//   lk_off   - bit offset of (table, lane) within lk_data
package ch_param_pkg;

  typedef enum logic [1:0] {INIT, IDLE, COPY} state_e;

  typedef enum logic [1:0] {OP_NONE, OP_CLR, OP_WR, OP_CP} mem_op_e;

  localparam int unsigned TAB_THR    = 0;
  localparam int unsigned TAB_HASH   = 1;
  localparam int unsigned TAB_OFFSET = 2;
  localparam int unsigned TAB_GRPNO  = 3;
  localparam int unsigned TAB_REF    = 4;

  function automatic int unsigned tab_base(input int unsigned tab,
                                           input int unsigned num_ch);
    return tab * num_ch;
  endfunction

  function automatic int unsigned lk_off(input int unsigned tab,
                                         input int unsigned lane,
                                         input int unsigned num_lane,
                                         input int unsigned data_w);
    return (tab * num_lane + lane) * data_w;
  endfunction

endpackage

// File: rtl/ch_param_bank.sv
// ch_param_bank: one table, two banks of NUM_CH entries each.
//   clk_i, rst_i  - clock, synchronous active-high reset (lookup regs only)
//   op_i          - OP_CLR zeroes addr_i in both banks; OP_WR writes wdata_i
//                   to bank_i; OP_CP copies the other bank into bank_i
//   bank_i        - shadow bank: write/copy destination and host read source
//   addr_i        - entry index for host/copy/clear port
//   wdata_i       - host write data
//   rdata_o       - combinational read of bank_i[addr_i]
//   lk_en_i       - enables lookups (otherwise lookups return 0)
//   lk_bank_i     - bank served to lookups
//   lk_ch_i       - NUM_LANE channel indices, lane 0 in LSBs
//   lk_data_o     - registered lookup data, lane 0 in LSBs
module ch_param_bank
  import ch_param_pkg::*;
#(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned CH_W     = 12,
  parameter int unsigned NUM_CH   = 256,
  parameter int unsigned NUM_LANE = 5,
  parameter int unsigned IDX_W    = $clog2(NUM_CH)
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  mem_op_e                    op_i,
  input  logic                       bank_i,
  input  logic [IDX_W-1:0]           addr_i,
  input  logic [DATA_W-1:0]          wdata_i,
  output logic [DATA_W-1:0]          rdata_o,
  input  logic                       lk_en_i,
  input  logic                       lk_bank_i,
  input  logic [NUM_LANE*CH_W-1:0]   lk_ch_i,
  output logic [NUM_LANE*DATA_W-1:0] lk_data_o
);

  logic [DATA_W-1:0]          mem_q [2][NUM_CH];
  logic [NUM_LANE*DATA_W-1:0] lk_d, lk_q;

  always_ff @(posedge clk_i) begin
    unique case (op_i)
      OP_CLR: begin
        mem_q[0][addr_i] <= '0;
        mem_q[1][addr_i] <= '0;
      end
      OP_WR:   mem_q[bank_i][addr_i] <= wdata_i;
      OP_CP:   mem_q[bank_i][addr_i] <= mem_q[~bank_i][addr_i];
      default: ;
    endcase
  end

  assign rdata_o = mem_q[bank_i][addr_i];

  // Any set bit above the entry index makes the lane out of range.
  always_comb begin
    lk_d = '0;
    for (int unsigned l = 0; l < NUM_LANE; l++) begin
      if (lk_en_i && ((lk_ch_i[l*CH_W +: CH_W] >> IDX_W) == '0))
        lk_d[l*DATA_W +: DATA_W] = mem_q[lk_bank_i][lk_ch_i[l*CH_W +: IDX_W]];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) lk_q <= '0;
    else       lk_q <= lk_d;
  end

  assign lk_data_o = lk_q;

endmodule

// File: rtl/ch_param_ram.sv
// ch_param_ram: double-buffered per-channel parameter store.
// Host writes go to the shadow bank; commit swaps banks and then copies the
// new active bank back into the shadow so both match again.
// Optional feature macro CH_PARAM_OOR_FLAG_EN adds err_clr/err_oor, a sticky
// flag for out-of-range lookups and host accesses.
//   clk, rst            - clock, synchronous active-high reset
//   host_addr/wdata     - host word address (table*NUM_CH + ch) and data
//   host_we/re          - write/read requests, accepted while host_ready
//   host_ready          - high only in IDLE
//   host_rdata/rvalid   - shadow-bank read data, valid one cycle after read
//   commit/commit_done  - bank swap request / pulse when the copy ends
//   bank_sel            - active bank index
//   lk_ch/lk_valid      - NUM_LANE lookup indices and qualifier
//   lk_data/lk_valid_out- registered lookup data per table/lane, qualifier
module ch_param_ram
  import ch_param_pkg::*;
#(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned CH_W     = 12,
  parameter int unsigned NUM_CH   = 256,
  parameter int unsigned NUM_LANE = 5,
  parameter int unsigned NUM_TAB  = 5,
  parameter int unsigned ADDR_W   = 16
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [ADDR_W-1:0]                  host_addr,
  input  logic [DATA_W-1:0]                  host_wdata,
  input  logic                               host_we,
  input  logic                               host_re,
  output logic                               host_ready,
  output logic [DATA_W-1:0]                  host_rdata,
  output logic                               host_rvalid,
  input  logic                               commit,
  output logic                               commit_done,
  output logic                               bank_sel,
  input  logic [NUM_LANE*CH_W-1:0]           lk_ch,
  input  logic                               lk_valid,
  output logic [NUM_TAB*NUM_LANE*DATA_W-1:0] lk_data,
  output logic                               lk_valid_out
`ifdef CH_PARAM_OOR_FLAG_EN
  ,
  input  logic                               err_clr,
  output logic                               err_oor
`endif
);

  localparam int unsigned      IDX_W    = $clog2(NUM_CH);
  localparam logic [ADDR_W:0]  ADDR_LIM = (ADDR_W+1)'(NUM_TAB * NUM_CH);

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  cnt_q, cnt_d;
  logic              bank_sel_q, bank_sel_d;
  logic              commit_done_q, commit_done_d;
  logic              rvalid_q, rvalid_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              lk_valid_q;

  logic [ADDR_W-1:0] host_tab;
  logic [IDX_W-1:0]  host_ch;
  logic              in_range;
  logic              acc_we;
  mem_op_e           op_base;
  logic [IDX_W-1:0]  bank_addr;
  logic [DATA_W-1:0] tab_rdata [NUM_TAB];
  logic [DATA_W-1:0] rd_mux;

  assign host_tab   = host_addr >> IDX_W;
  assign host_ch    = host_addr[IDX_W-1:0];
  assign in_range   = {1'b0, host_addr} < ADDR_LIM;
  assign host_ready = (state_q == IDLE);
  assign acc_we     = host_ready && host_we && in_range;
  assign bank_addr  = host_ready ? host_ch : cnt_q;

  always_comb begin
    op_base = OP_NONE;
    if (state_q == INIT) op_base = OP_CLR;
    if (state_q == COPY) op_base = OP_CP;
  end

  // Shadow is always ~bank_sel_q: host writes land there, and during COPY
  // (bank_sel already toggled) it is the copy destination.
  // Lookups use bank_sel_d so the commit edge already serves the new bank.
  for (genvar t = 0; t < NUM_TAB; t++) begin : g_tab
    mem_op_e op;
    always_comb begin
      op = op_base;
      if (acc_we && (host_tab == ADDR_W'(t))) op = OP_WR;
    end
    ch_param_bank #(
      .DATA_W  (DATA_W),
      .CH_W    (CH_W),
      .NUM_CH  (NUM_CH),
      .NUM_LANE(NUM_LANE),
      .IDX_W   (IDX_W)
    ) u_bank (
      .clk_i    (clk),
      .rst_i    (rst),
      .op_i     (op),
      .bank_i   (~bank_sel_q),
      .addr_i   (bank_addr),
      .wdata_i  (host_wdata),
      .rdata_o  (tab_rdata[t]),
      .lk_en_i  (state_q != INIT),
      .lk_bank_i(bank_sel_d),
      .lk_ch_i  (lk_ch),
      .lk_data_o(lk_data[lk_off(t, 0, NUM_LANE, DATA_W) +: NUM_LANE*DATA_W])
    );
  end

  always_comb begin
    rd_mux = '0;
    for (int unsigned t = 0; t < NUM_TAB; t++)
      if (host_tab == ADDR_W'(t)) rd_mux = tab_rdata[t];
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    bank_sel_d    = bank_sel_q;
    commit_done_d = 1'b0;
    rvalid_d      = 1'b0;
    rdata_d       = rdata_q;
    unique case (state_q)
      INIT: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == '1) state_d = IDLE;
      end
      IDLE: begin
        if (host_re) begin
          rvalid_d = 1'b1;
          rdata_d  = in_range ? rd_mux : '0;
        end
        if (commit) begin
          bank_sel_d = ~bank_sel_q;
          cnt_d      = '0;
          state_d    = COPY;
        end
      end
      COPY: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == '1) begin
          state_d       = IDLE;
          commit_done_d = 1'b1;
        end
      end
      default: state_d = INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= INIT;
      cnt_q         <= '0;
      bank_sel_q    <= 1'b0;
      commit_done_q <= 1'b0;
      rvalid_q      <= 1'b0;
      rdata_q       <= '0;
      lk_valid_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      bank_sel_q    <= bank_sel_d;
      commit_done_q <= commit_done_d;
      rvalid_q      <= rvalid_d;
      rdata_q       <= rdata_d;
      lk_valid_q    <= lk_valid;
    end
  end

  assign host_rdata   = rdata_q;
  assign host_rvalid  = rvalid_q;
  assign commit_done  = commit_done_q;
  assign bank_sel     = bank_sel_q;
  assign lk_valid_out = lk_valid_q;

`ifdef CH_PARAM_OOR_FLAG_EN
  logic err_q, err_set;

  always_comb begin
    err_set = host_ready && (host_we || host_re) && !in_range;
    if (lk_valid)
      for (int unsigned l = 0; l < NUM_LANE; l++)
        if ((lk_ch[l*CH_W +: CH_W] >> IDX_W) != '0) err_set = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst)          err_q <= 1'b0;
    else if (err_set) err_q <= 1'b1;
    else if (err_clr) err_q <= 1'b0;
  end

  assign err_oor = err_q;
`endif

endmodule

// File: tb/tb_ch_param_ram.sv
module tb_ch_param_ram;
  import ch_param_pkg::*;

  localparam int NT  = 5;
  localparam int NC  = 256;
  localparam int NL  = 5;
  localparam int DW  = 32;
  localparam int CW  = 12;
  localparam int AW  = 16;
  localparam int LKW = NT * NL * DW;

  logic            clk = 1'b0;
  logic            rst;
  logic [AW-1:0]   host_addr;
  logic [DW-1:0]   host_wdata;
  logic            host_we, host_re, commit, lk_valid, err_clr;
  logic            host_ready, host_rvalid, commit_done, bank_sel, lk_valid_out;
  logic [DW-1:0]   host_rdata;
  logic [NL*CW-1:0] lk_ch;
  logic [LKW-1:0]  lk_data;
  logic            err_oor_w;

  ch_param_ram #(
    .DATA_W(DW), .CH_W(CW), .NUM_CH(NC), .NUM_LANE(NL), .NUM_TAB(NT), .ADDR_W(AW)
  ) dut (
    .clk(clk), .rst(rst),
    .host_addr(host_addr), .host_wdata(host_wdata),
    .host_we(host_we), .host_re(host_re),
    .host_ready(host_ready), .host_rdata(host_rdata), .host_rvalid(host_rvalid),
    .commit(commit), .commit_done(commit_done), .bank_sel(bank_sel),
    .lk_ch(lk_ch), .lk_valid(lk_valid),
    .lk_data(lk_data), .lk_valid_out(lk_valid_out)
`ifdef CH_PARAM_OOR_FLAG_EN
    , .err_clr(err_clr), .err_oor(err_oor_w)
`endif
  );

`ifndef CH_PARAM_OOR_FLAG_EN
  assign err_oor_w = 1'b0;
`endif

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Behavioural model: logical active/shadow parameter sets and busy timers.
  logic [DW-1:0] act [NT][NC];
  logic [DW-1:0] shd [NT][NC];
  int            init_left, copy_left;
  logic          e_ready, e_bank, e_cd, e_rv, e_lvo, e_err;
  logic [DW-1:0] e_rd;
  logic [LKW-1:0] e_lk;

  task automatic chk(input string name, input logic [LKW-1:0] got, input logic [LKW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic predict();
    logic ready, set;
    int a, c;
    logic [LKW-1:0] lk;
    if (rst) begin
      for (int t = 0; t < NT; t++)
        for (int i = 0; i < NC; i++) begin
          act[t][i] = '0;
          shd[t][i] = '0;
        end
      init_left = NC; copy_left = 0;
      e_bank = 0; e_cd = 0; e_rv = 0; e_rd = '0; e_lvo = 0; e_lk = '0; e_err = 0;
    end else begin
      ready = (init_left == 0) && (copy_left == 0);
      a = int'(host_addr);
      e_lvo = lk_valid;
      lk = '0;
      set = ready && (host_we || host_re) && (a >= NT*NC);
      for (int l = 0; l < NL; l++) begin
        c = int'(lk_ch[l*CW +: CW]);
        if (c >= NC) set = set || lk_valid;
        else if (init_left == 0)
          for (int t = 0; t < NT; t++)
            lk[(t*NL + l)*DW +: DW] = (ready && commit) ? shd[t][c] : act[t][c];
      end
      e_lk = lk;
      e_err = set ? 1'b1 : (err_clr ? 1'b0 : e_err);
      e_cd = 0; e_rv = 0;
      if (ready && host_re) begin
        e_rv = 1;
        e_rd = (a < NT*NC) ? shd[a/NC][a%NC] : '0;
      end
      if (ready && host_we && a < NT*NC) shd[a/NC][a%NC] = host_wdata;
      if (init_left > 0) init_left--;
      else if (copy_left > 0) begin
        copy_left--;
        if (copy_left == 0) e_cd = 1;
      end else if (commit) begin
        for (int t = 0; t < NT; t++)
          for (int i = 0; i < NC; i++) act[t][i] = shd[t][i];
        e_bank = ~e_bank;
        copy_left = NC;
      end
    end
    e_ready = (init_left == 0) && (copy_left == 0);
  endtask

  task automatic cycle();
    predict();
    @(posedge clk);
    #1;
    chk("host_ready", host_ready, e_ready);
    chk("bank_sel", bank_sel, e_bank);
    chk("commit_done", commit_done, e_cd);
    chk("host_rvalid", host_rvalid, e_rv);
    chk("host_rdata", host_rdata, e_rd);
    chk("lk_valid_out", lk_valid_out, e_lvo);
    chk("lk_data", lk_data, e_lk);
`ifdef CH_PARAM_OOR_FLAG_EN
    chk("err_oor", err_oor_w, e_err);
`endif
  endtask

  task automatic set_lane(input int l, input int v);
    lk_ch[l*CW +: CW] = CW'(v);
  endtask

  task automatic idle_inputs();
    host_we = 0; host_re = 0; commit = 0; err_clr = 0;
  endtask

  task automatic wait_ready(input string name);
    int k;
    for (k = 0; k < 400; k++) begin
      if (host_ready === 1'b1) break;
      cycle();
    end
    if (k == 400) chk(name, host_ready, 1'b1);
  endtask

  function automatic logic [DW-1:0] lk_slice(input int t, input int l);
    return lk_data[lk_off(t, l, NL, DW) +: DW];
  endfunction

  initial begin
    int n, k;
    rst = 1; idle_inputs();
    host_addr = '0; host_wdata = '0;
    lk_valid = 1;
    for (int l = 0; l < NL; l++) set_lane(l, 7);
    repeat (3) cycle();

    // INIT length: reset sample plus every INIT cycle after release.
    rst = 0; n = 1;
    for (k = 0; k < 400; k++) begin
      cycle();
      if (host_ready === 1'b1) break;
      n++;
    end
    chk("init_len", n, 256);
    cycle();
    chk("init_lookup_zero", lk_data, '0);

    // Shadow write is readable but invisible to lookups until commit.
    for (int l = 0; l < NL; l++) set_lane(l, 0);
    set_lane(2, 3);
    host_addr = AW'(tab_base(TAB_THR, NC) + 3); host_wdata = 32'hFFFF_FF80;
    host_we = 1; cycle(); host_we = 0;
    host_re = 1; cycle(); host_re = 0;
    chk("rd_addr3", host_rdata, 32'hFFFF_FF80);
    chk("rd_addr3_valid", host_rvalid, 1'b1);
    chk("lk_precommit", lk_slice(TAB_THR, 2), 32'h0);
    commit = 1; cycle(); commit = 0;
    chk("bank_toggle", bank_sel, 1'b1);
    chk("lk_at_toggle", lk_slice(TAB_THR, 2), 32'hFFFF_FF80);

    // COPY length and shadow content after copy.
    n = 0;
    for (k = 0; k < 400; k++) begin
      cycle(); n++;
      if (commit_done === 1'b1) break;
    end
    chk("copy_len", n, 256);
    host_re = 1; cycle(); host_re = 0;
    chk("rd_after_copy", host_rdata, 32'hFFFF_FF80);

    // Read-first on same-address write+read, then out-of-range access.
    host_addr = AW'(tab_base(TAB_REF, NC) + 4); host_wdata = 32'h21;
    host_we = 1; host_re = 1; cycle(); host_we = 0;
    chk("rw_old", host_rdata, 32'h0);
    cycle(); host_re = 0;
    chk("rw_new", host_rdata, 32'h21);
    host_addr = 16'd1280; host_wdata = 32'h5;
    host_we = 1; host_re = 1; cycle(); idle_inputs();
    chk("oor_rd", host_rdata, 32'h0);
    chk("oor_rv", host_rvalid, 1'b1);

`ifdef CH_PARAM_OOR_FLAG_EN
    lk_valid = 0;
    err_clr = 1; cycle(); err_clr = 0;
    chk("err_cleared0", err_oor_w, 1'b0);
    lk_valid = 1; set_lane(4, 300); cycle();
    chk("err_set", err_oor_w, 1'b1);
    lk_valid = 0; err_clr = 1; cycle();
    chk("err_clr", err_oor_w, 1'b0);
    lk_valid = 1; cycle(); err_clr = 0;
    chk("err_set_prio", err_oor_w, 1'b1);
    set_lane(4, 0);
`endif

    // Randomized traffic against the model.
    for (int i = 0; i < 2500; i++) begin
      int r;
      host_we = ($urandom % 3) == 0;
      host_re = ($urandom % 3) == 0;
      commit  = ($urandom % 64) == 0;
      err_clr = ($urandom % 8) == 0;
      r = $urandom % 16;
      if (r == 0) host_addr = AW'($urandom_range(1280, 65535));
      else        host_addr = AW'(($urandom % NT) * NC + ($urandom % 8));
      host_wdata = $urandom;
      lk_valid = $urandom % 2;
      for (int l = 0; l < NL; l++)
        set_lane(l, (($urandom % 10) == 0) ? $urandom_range(256, 4095) : ($urandom % 8));
      cycle();
    end
    idle_inputs(); lk_valid = 0;

    // Reset in the middle of COPY.
    wait_ready("ready_before_commit");
    host_addr = 16'd3; host_wdata = 32'h1234_5678; host_we = 1;
    commit = 1; cycle(); idle_inputs();
    repeat (100) cycle();
    rst = 1; cycle(); rst = 0;
    chk("rst_bank", bank_sel, 1'b0);
    chk("rst_ready", host_ready, 1'b0);
    chk("rst_lk", lk_data, '0);
    wait_ready("ready_after_reset");
    lk_valid = 1;
    for (int l = 0; l < NL; l++) set_lane(l, l + 2);
    host_addr = 16'd3; host_re = 1; cycle(); idle_inputs();
    chk("post_reset_lk", lk_data, '0);
    chk("post_reset_rd", host_rdata, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ch_param_ram.md
Name: ch_param_ram

Overview:
- Parametrised, double-buffered per-channel parameter store.
- Holds NUM_TAB tables (threshold, channel hash, offset, group No, reference channel, ...) of NUM_CH entries each.
- Serves NUM_LANE streaming channel lookups per cycle to spike detection and grouping logic.
- Host writes land in a shadow bank and become visible atomically on a commit. Streaming lookups therefore never see a partially updated parameter set.

Parameters:
- DATA_W, 32: width of one table entry
- CH_W, 12: width of one channel index
- NUM_CH, 256: entries per table (channels); power of two, ≤ 2**CH_W
- NUM_LANE, 5: parallel lookup lanes (chips)
- NUM_TAB, 5: number of tables
- ADDR_W, 16: host address width; must satisfy NUM_TAB*NUM_CH ≤ 2**ADDR_W

Ports:
- clk  in  1  single clock
- rst  in  1  synchronous, active-high reset
- host_addr  in  ADDR_W  word address; table t occupies t*NUM_CH .. (t+1)*NUM_CH-1
- host_wdata  in  DATA_W  write data
- host_we  in  1  write request
- host_re  in  1  read request
- host_ready  out  1  high only in IDLE; requests are accepted only when high
- host_rdata  out  DATA_W  read data, shadow bank
- host_rvalid  out  1  one-cycle pulse, one cycle after an accepted read
- commit  in  1  swap shadow/active; accepted only when host_ready
- commit_done  out  1  one-cycle pulse when COPY finishes
- bank_sel  out  1  index of the active bank
- lk_ch  in  NUM_LANE*CH_W  lane channel indices; lane 0 in the LSBs
- lk_valid  in  1  lookup qualifier
- lk_data  out  NUM_TAB*NUM_LANE*DATA_W  table t, lane l at offset (t*NUM_LANE+l)*DATA_W
- lk_valid_out  out  1  lk_valid delayed by 1

Behaviour:
- Storage: 2 banks × NUM_TAB tables × NUM_CH entries, inferred as block RAM.
- States: INIT, IDLE, COPY.
- Reset (rst high, in any state, including mid-COPY):
  - state→INIT, clear counter→0, bank_sel→0.
  - host_ready, host_rvalid, commit_done, lk_valid_out→0; host_rdata→0; lk_data→0.
- INIT:
  - Writes 0 to entry cnt of every table in both banks each cycle; cnt runs 0..NUM_CH-1.
  - Enters IDLE the cycle after cnt=NUM_CH-1, so INIT lasts exactly NUM_CH cycles.
  - lk_data is forced to 0 throughout INIT.
- IDLE, host_ready=1:
  - Accepted write: shadow[table][ch] <= host_wdata.
  - Accepted read: host_rdata <= shadow[table][ch] with host_rvalid=1 the next cycle (latency 1).
  - Simultaneous we+re on the same address is read-first: the read returns the old value and the write lands.
  - Address ≥ NUM_TAB*NUM_CH: writes are dropped; reads return 0 with host_rvalid=1.
- commit in IDLE:
  - bank_sel toggles on the next edge; state→COPY; host_ready drops the cycle after.
  - A write accepted in the same cycle as commit is applied to the old shadow first, so it becomes active.
- COPY:
  - Each cycle, for entry cnt of every table: new shadow <= new active.
  - NUM_CH cycles, then IDLE with commit_done high for 1 cycle.
  - The shadow bank is now identical to the active bank.
  - commit, host_we and host_re are ignored while host_ready=0.
- Lookup:
  - Registered, latency 1 from lk_ch to lk_data; operates in IDLE and COPY and reads the active bank only.
  - lk_data updates every cycle regardless of lk_valid; lk_valid only gates lk_valid_out.
  - A lane index ≥ NUM_CH returns 0 for all tables on that lane.
  - The lookup at the bank_sel toggle edge uses the new bank.
- Widths: entries are raw DATA_W bit vectors with no sign handling; table = host_addr / NUM_CH and ch = host_addr % NUM_CH, both via shifts.

Optional Feature:
- Macro CH_PARAM_OOR_FLAG_EN.
- Defined:
  - Adds output err_oor (1 bit) and input err_clr (1 bit).
  - err_oor is a sticky flag set the cycle after any lookup lane with lk_valid=1 and index ≥ NUM_CH, or any accepted host access with address ≥ NUM_TAB*NUM_CH.
  - Cleared by rst or err_clr; set has priority over clear in the same cycle.
- Undefined: neither port exists and out-of-range accesses are silent; data behaviour is identical in both builds.

Decomposition:
- Shared package ch_param_pkg holds:
  - the state enum (INIT/IDLE/COPY);
  - table index constants TAB_THR=0, TAB_HASH=1, TAB_OFFSET=2, TAB_GRPNO=3, TAB_REF=4;
  - localparam helpers for table base address and lk_data slice offset.
- Sub-module ch_param_bank: one dual-bank, single-table memory with a host/copy port and NUM_LANE read ports. It is instantiated NUM_TAB times via generate; the top holds the FSM, counter and address decode.

Test Plan:
- Reset, then hold rst low: host_ready=0 for exactly 256 cycles then 1; a lookup of ch 7 in every lane returns 0 for all tables.
- Write addr 3 (thr ch3)=0xFFFF_FF80, then read addr 3: the read returns 0xFFFF_FF80, but lk_ch lane2=3 returns 0 until commit. After commit, at the bank_sel toggle edge, lookups return 0xFFFF_FF80.
- Commit, then lookup every cycle through COPY: lk_data is stable with the new values. commit_done pulses 256 cycles after the toggle, and a subsequent read of addr 3 returns 0xFFFF_FF80 (shadow copied).
- Same-cycle write addr 1028 (ref ch4)=0x21 and read addr 1028: host_rdata is the old value; the next read gives 0x21. Address 1280: write dropped, read returns 0.
- Assert rst at COPY cycle 100: state returns to INIT, bank_sel=0, everything is cleared, and all lookups return 0 after INIT.
- With CH_PARAM_OOR_FLAG_EN: lk_valid=1 with lane4 index 300 sets err_oor next cycle; err_clr clears it; a simultaneous new violation keeps it set.
